serial_word_tx: RTL

//  Parallel-to-serial word transmitter. Drives the bit-serial two's-complement datapath: it turns

---
 rtl/serial_word_tx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter, LSB first, with word-start marker
module serial_word_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_i,
    output logic             ser_r,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [3:0]       gap_cnt, gap_n;
    logic             ser_r_q, ser_r_n;
    logic             load;
    logic             accept;

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            ser_r_q   <= 1'b0;
        end else begin
            state     <= state_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shift_q   <= shift_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_n;
            ser_r_q   <= ser_r_n;
        end
    end

    // The line bit is shift_q[0]; the register is cleared whenever the line must idle low.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        cnt_n   = cnt;
        gap_n   = gap_cnt;
        ser_r_n = 1'b0;
        load    = 1'b0;
        accept  = din_valid && !hold_full;

        case (state)
            ST_IDLE: begin
                shift_n = '0;
                load    = hold_full;
            end
            ST_SHIFT: begin
                if (cnt != CNT_LAST) begin
                    shift_n = shift_q >> 1;
                    cnt_n   = cnt + CNT_ONE;
                end else if (GAP > 0) begin
                    shift_n = '0;
                    gap_n   = GAP_LOAD;
                    state_n = ST_GAP;
                end else if (hold_full) begin
                    load = 1'b1;
                end else begin
                    shift_n = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_GAP: begin
                shift_n = '0;
                if (gap_cnt == 4'd0) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    gap_n = gap_cnt - 4'd1;
                end
            end
            default: begin
                shift_n = '0;
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            shift_n = hold;
            ser_r_n = 1'b1;
            cnt_n   = '0;
            state_n = ST_SHIFT;
        end

        // Accept and drain are mutually exclusive: accept needs hold empty, drain needs it full.
        hold_n      = accept ? din : hold;
        hold_full_n = load ? 1'b0 : (accept ? 1'b1 : hold_full);
    end

    assign din_ready = !hold_full;
    assign ser_i     = shift_q[0];
    assign ser_r     = ser_r_q;
    assign busy      = (state != ST_IDLE) || hold_full;

endmodule
